alu_arbiter: RTL and testbench

Shares the single registered ALU (op result plus branch comparator) between two requesters: requester 0 is the execute stage and requester 1 is a secondary client such as address generation or debug. Each cycle the block picks one valid request, steers its operands into the ALU and gates the ALU clock enable. It then routes the ALU's registered result back to the owning requester through a valid/ready response handshake. Sustained throughput is one operation per cycle; result latency is one cycle.

---
 rtl/alu_arbiter_pkg.sv | 40 ++++
 rtl/alu_arbiter_rr_pick2.sv | 22 ++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: operand width, ALU op and branch
// condition encodings, requester IDs and a small one-hot helper.
package alu_arbiter_pkg;

  localparam int unsigned RvXlen   = 32;
  localparam int unsigned AluOpW   = 4;
  localparam int unsigned AluCondW = 3;

  // Requester IDs: execute stage and the auxiliary client (AGU / debug).
  localparam logic AluArbReqExe = 1'b0;
  localparam logic AluArbReqAux = 1'b1;

  typedef enum logic [AluOpW-1:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSlt  = 4'd2,
    AluSltu = 4'd3,
    AluXor  = 4'd4,
    AluOr   = 4'd5,
    AluAnd  = 4'd6,
    AluSll  = 4'd7,
    AluSrl  = 4'd8,
    AluSra  = 4'd9
  } alu_op_e;

  // Branch conditions use the RISC-V funct3 encoding.
  typedef enum logic [AluCondW-1:0] {
    CondEq  = 3'd0,
    CondNe  = 3'd1,
    CondLt  = 3'd4,
    CondGe  = 3'd5,
    CondLtu = 3'd6,
    CondGeu = 3'd7
  } alu_cond_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Combinational 2-way request picker, reusable by any shared-resource arbiter.
//   valid_i   : per-requester valid
//   prio_i    : favoured requester when both are valid in round-robin mode
//   rr_mode_i : 1 = round-robin (use prio_i), 0 = fixed priority (requester 0 wins)
//   pick_o    : selected requester index (0 when nothing is valid)
module alu_arbiter_rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  input  logic       rr_mode_i,
  output logic       pick_o
);

  always_comb begin
    pick_o = 1'b0;
    case (valid_i)
      2'b10:   pick_o = 1'b1;
      2'b11:   pick_o = rr_mode_i & prio_i;
      default: pick_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU (op result + branch comparator) between the execute
// stage (requester 0) and an auxiliary client (requester 1).
//   clk_i, resetb_i, clk_en_i  : clock, async active-low reset, pipeline enable
//   req_valid_i / req_ready_o  : per-requester request handshake (ready is comb)
//   req{0,1}_*_i               : per-requester operands and opcodes
//   rsp_valid_o / rsp_ready_i  : per-requester response handshake
//   rsp_result_o, rsp_cmp_o    : ALU registered results passed through
//   alu_*_o, alu_clk_en_o      : steered operands and ALU clock enable
//   alu_op_result_i, alu_cmp_result_i : ALU registered outputs
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned XLEN        = RvXlen
) (
  input  logic                clk_i,
  input  logic                resetb_i,
  input  logic                clk_en_i,

  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,

  input  logic [XLEN-1:0]     req0_op_left_i,
  input  logic [XLEN-1:0]     req0_op_right_i,
  input  logic [AluOpW-1:0]   req0_op_opcode_i,
  input  logic [XLEN-1:0]     req0_cmp_left_i,
  input  logic [XLEN-1:0]     req0_cmp_right_i,
  input  logic [AluCondW-1:0] req0_cmp_opcode_i,

  input  logic [XLEN-1:0]     req1_op_left_i,
  input  logic [XLEN-1:0]     req1_op_right_i,
  input  logic [AluOpW-1:0]   req1_op_opcode_i,
  input  logic [XLEN-1:0]     req1_cmp_left_i,
  input  logic [XLEN-1:0]     req1_cmp_right_i,
  input  logic [AluCondW-1:0] req1_cmp_opcode_i,

  output logic [1:0]          rsp_valid_o,
  input  logic [1:0]          rsp_ready_i,
  output logic [XLEN-1:0]     rsp_result_o,
  output logic                rsp_cmp_o,

  output logic                alu_clk_en_o,
  output logic [XLEN-1:0]     alu_op_left_o,
  output logic [XLEN-1:0]     alu_op_right_o,
  output logic [AluOpW-1:0]   alu_op_opcode_o,
  output logic [XLEN-1:0]     alu_cmp_left_o,
  output logic [XLEN-1:0]     alu_cmp_right_o,
  output logic [AluCondW-1:0] alu_cmp_opcode_o,
  input  logic [XLEN-1:0]     alu_op_result_i,
  input  logic                alu_cmp_result_i
);

  logic pending_q, pending_d;
  logic owner_q, owner_d;
  logic prio_q, prio_d;
  logic cand;
  logic rsp_accept;
  logic can_issue;
  logic issue;

  alu_arbiter_rr_pick2 u_pick (
    .valid_i   (req_valid_i),
    .prio_i    (prio_q),
    .rr_mode_i (ROUND_ROBIN),
    .pick_o    (cand)
  );

  // Handshakes depend only on state and valid/ready inputs, never on the result.
  assign rsp_accept = pending_q & rsp_ready_i[owner_q] & clk_en_i;
  // resetb_i keeps ready/clk_en low while reset is held.
  assign can_issue  = clk_en_i & resetb_i & (~pending_q | rsp_accept);
  assign issue      = can_issue & req_valid_i[cand];

  assign req_ready_o  = issue ? onehot2(cand) : 2'b00;
  assign rsp_valid_o  = pending_q ? onehot2(owner_q) : 2'b00;
  assign alu_clk_en_o = issue;

  // The ALU only clocks on issue, so its registered result is stable until accepted.
  assign rsp_result_o = alu_op_result_i;
  assign rsp_cmp_o    = alu_cmp_result_i;

  always_comb begin
    if (cand == AluArbReqAux) begin
      alu_op_left_o    = req1_op_left_i;
      alu_op_right_o   = req1_op_right_i;
      alu_op_opcode_o  = req1_op_opcode_i;
      alu_cmp_left_o   = req1_cmp_left_i;
      alu_cmp_right_o  = req1_cmp_right_i;
      alu_cmp_opcode_o = req1_cmp_opcode_i;
    end else begin
      alu_op_left_o    = req0_op_left_i;
      alu_op_right_o   = req0_op_right_i;
      alu_op_opcode_o  = req0_op_opcode_i;
      alu_cmp_left_o   = req0_cmp_left_i;
      alu_cmp_right_o  = req0_cmp_right_i;
      alu_cmp_opcode_o = req0_cmp_opcode_i;
    end
  end

  always_comb begin
    pending_d = pending_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    if (issue) begin
      // Covers back-to-back: a same-cycle accept is replaced by the new op.
      pending_d = 1'b1;
      owner_d   = cand;
      if (ROUND_ROBIN) begin
        prio_d = ~cand;
      end
    end else if (rsp_accept) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      pending_q <= 1'b0;
      owner_q   <= AluArbReqExe;
      prio_q    <= AluArbReqExe;
    end else if (clk_en_i) begin
      pending_q <= pending_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetb;
  logic        clk_en;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] r0_l, r0_r, r0_cl, r0_cr, r1_l, r1_r, r1_cl, r1_cr;
  logic [3:0]  r0_op, r1_op;
  logic [2:0]  r0_cop, r1_cop;

  // Round-robin instance outputs
  logic [1:0]  rr_ready, rr_valid;
  logic [31:0] rr_rsp_res, rr_al, rr_ar, rr_cl, rr_cr, rr_res;
  logic        rr_rsp_cmp, rr_alu_en, rr_cmp;
  logic [3:0]  rr_op;
  logic [2:0]  rr_cop;
  // Fixed-priority instance outputs
  logic [1:0]  fp_ready, fp_valid;
  logic [31:0] fp_rsp_res, fp_al, fp_ar, fp_cl, fp_cr, fp_res;
  logic        fp_rsp_cmp, fp_alu_en, fp_cmp;
  logic [3:0]  fp_op;
  logic [2:0]  fp_cop;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.ROUND_ROBIN(1'b1), .XLEN(32)) u_dut_rr (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en),
    .req_valid_i(req_valid), .req_ready_o(rr_ready),
    .req0_op_left_i(r0_l), .req0_op_right_i(r0_r), .req0_op_opcode_i(r0_op),
    .req0_cmp_left_i(r0_cl), .req0_cmp_right_i(r0_cr), .req0_cmp_opcode_i(r0_cop),
    .req1_op_left_i(r1_l), .req1_op_right_i(r1_r), .req1_op_opcode_i(r1_op),
    .req1_cmp_left_i(r1_cl), .req1_cmp_right_i(r1_cr), .req1_cmp_opcode_i(r1_cop),
    .rsp_valid_o(rr_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rr_rsp_res), .rsp_cmp_o(rr_rsp_cmp),
    .alu_clk_en_o(rr_alu_en), .alu_op_left_o(rr_al), .alu_op_right_o(rr_ar),
    .alu_op_opcode_o(rr_op), .alu_cmp_left_o(rr_cl), .alu_cmp_right_o(rr_cr),
    .alu_cmp_opcode_o(rr_cop), .alu_op_result_i(rr_res), .alu_cmp_result_i(rr_cmp)
  );

  alu_arbiter #(.ROUND_ROBIN(1'b0), .XLEN(32)) u_dut_fp (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en),
    .req_valid_i(req_valid), .req_ready_o(fp_ready),
    .req0_op_left_i(r0_l), .req0_op_right_i(r0_r), .req0_op_opcode_i(r0_op),
    .req0_cmp_left_i(r0_cl), .req0_cmp_right_i(r0_cr), .req0_cmp_opcode_i(r0_cop),
    .req1_op_left_i(r1_l), .req1_op_right_i(r1_r), .req1_op_opcode_i(r1_op),
    .req1_cmp_left_i(r1_cl), .req1_cmp_right_i(r1_cr), .req1_cmp_opcode_i(r1_cop),
    .rsp_valid_o(fp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(fp_rsp_res), .rsp_cmp_o(fp_rsp_cmp),
    .alu_clk_en_o(fp_alu_en), .alu_op_left_o(fp_al), .alu_op_right_o(fp_ar),
    .alu_op_opcode_o(fp_op), .alu_cmp_left_o(fp_cl), .alu_cmp_right_o(fp_cr),
    .alu_cmp_opcode_o(fp_cop), .alu_op_result_i(fp_res), .alu_cmp_result_i(fp_cmp)
  );

  function automatic logic [31:0] alu_eval(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      AluAdd:  return a + b;
      AluSub:  return a - b;
      AluSlt:  return {31'd0, $signed(a) < $signed(b)};
      AluSltu: return {31'd0, a < b};
      AluXor:  return a ^ b;
      AluOr:   return a | b;
      AluAnd:  return a & b;
      AluSll:  return a << b[4:0];
      AluSrl:  return a >> b[4:0];
      AluSra:  return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic cmp_eval(input logic [2:0] c, input logic [31:0] a,
                                    input logic [31:0] b);
    case (c)
      CondEq:  return a == b;
      CondNe:  return a != b;
      CondLt:  return $signed(a) < $signed(b);
      CondGe:  return $signed(a) >= $signed(b);
      CondLtu: return a < b;
      CondGeu: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural registered ALU for each instance.
  always_ff @(posedge clk) begin
    if (rr_alu_en) begin
      rr_res <= alu_eval(rr_op, rr_al, rr_ar);
      rr_cmp <= cmp_eval(rr_cop, rr_cl, rr_cr);
    end
    if (fp_alu_en) begin
      fp_res <= alu_eval(fp_op, fp_al, fp_ar);
      fp_cmp <= cmp_eval(fp_cop, fp_cl, fp_cr);
    end
  end

  // Operand sets
  logic [3:0]  set_op[5];
  logic [31:0] set_l[5], set_r[5], set_cl[5], set_cr[5];
  logic [2:0]  set_cop[5];

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  rdy;
    logic        en;
    int          s0;
    int          s1;
    logic [1:0]  ex_ready;
    logic [1:0]  ex_valid;
    logic [31:0] ex_res;
    logic        ex_cmp;
    logic        ex_alu_en;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_sets(input int a, input int b);
    r0_op = set_op[a]; r0_l = set_l[a]; r0_r = set_r[a];
    r0_cop = set_cop[a]; r0_cl = set_cl[a]; r0_cr = set_cr[a];
    r1_op = set_op[b]; r1_l = set_l[b]; r1_r = set_r[b];
    r1_cop = set_cop[b]; r1_cl = set_cl[b]; r1_cr = set_cr[b];
  endtask

  initial begin
    // S0: ADD 5+7=12, EQ 3,3=1     S1: SUB 10-3=7, NE 3,3=0
    // S2: SLT -1<2=1, LT -1,2=1     S3: XOR F0^FF=0F, GEU 1,2=0
    // S4: ADD 1+1=2, LTU 1,2=1
    set_op[0] = AluAdd; set_l[0] = 32'd5;  set_r[0] = 32'd7;
    set_cop[0] = CondEq;  set_cl[0] = 32'd3; set_cr[0] = 32'd3;
    set_op[1] = AluSub; set_l[1] = 32'd10; set_r[1] = 32'd3;
    set_cop[1] = CondNe;  set_cl[1] = 32'd3; set_cr[1] = 32'd3;
    set_op[2] = AluSlt; set_l[2] = 32'hFFFF_FFFF; set_r[2] = 32'd2;
    set_cop[2] = CondLt;  set_cl[2] = 32'hFFFF_FFFF; set_cr[2] = 32'd2;
    set_op[3] = AluXor; set_l[3] = 32'hF0; set_r[3] = 32'hFF;
    set_cop[3] = CondGeu; set_cl[3] = 32'd1; set_cr[3] = 32'd2;
    set_op[4] = AluAdd; set_l[4] = 32'd1;  set_r[4] = 32'd1;
    set_cop[4] = CondLtu; set_cl[4] = 32'd1; set_cr[4] = 32'd2;

    //          valid  rdy    en  s0 s1 ready  rspv   res     cmp alu_en
    vecs[0]  = '{2'b01, 2'b11, 1, 0, 2, 2'b01, 2'b00, 32'd0,  0, 1}; // single op issue
    vecs[1]  = '{2'b00, 2'b11, 1, 0, 2, 2'b00, 2'b01, 32'd12, 1, 0};
    vecs[2]  = '{2'b11, 2'b11, 1, 1, 2, 2'b10, 2'b00, 32'd0,  0, 1}; // prio=1 after grant 0
    vecs[3]  = '{2'b11, 2'b11, 1, 1, 2, 2'b01, 2'b10, 32'd1,  1, 1};
    vecs[4]  = '{2'b11, 2'b11, 1, 1, 2, 2'b10, 2'b01, 32'd7,  0, 1};
    vecs[5]  = '{2'b11, 2'b11, 1, 1, 2, 2'b01, 2'b10, 32'd1,  1, 1};
    vecs[6]  = '{2'b00, 2'b11, 1, 1, 2, 2'b00, 2'b01, 32'd7,  0, 0};
    vecs[7]  = '{2'b01, 2'b11, 1, 3, 2, 2'b01, 2'b00, 32'd0,  0, 1}; // XOR
    vecs[8]  = '{2'b01, 2'b10, 1, 4, 2, 2'b00, 2'b01, 32'h0F, 0, 0}; // stalled
    vecs[9]  = '{2'b01, 2'b10, 1, 4, 2, 2'b00, 2'b01, 32'h0F, 0, 0};
    vecs[10] = '{2'b01, 2'b10, 1, 4, 2, 2'b00, 2'b01, 32'h0F, 0, 0};
    vecs[11] = '{2'b01, 2'b11, 1, 4, 2, 2'b01, 2'b01, 32'h0F, 0, 1}; // back-to-back
    vecs[12] = '{2'b00, 2'b11, 1, 4, 2, 2'b00, 2'b01, 32'd2,  1, 0};
    vecs[13] = '{2'b10, 2'b11, 1, 4, 2, 2'b10, 2'b00, 32'd0,  0, 1}; // req1 alone
    vecs[14] = '{2'b11, 2'b11, 0, 4, 2, 2'b00, 2'b10, 32'd1,  1, 0}; // frozen
    vecs[15] = '{2'b11, 2'b11, 0, 4, 2, 2'b00, 2'b10, 32'd1,  1, 0};
    vecs[16] = '{2'b00, 2'b11, 1, 4, 2, 2'b00, 2'b10, 32'd1,  1, 0};
    vecs[17] = '{2'b00, 2'b11, 1, 4, 2, 2'b00, 2'b00, 32'd0,  0, 0};
    vecs[18] = '{2'b11, 2'b11, 1, 4, 2, 2'b01, 2'b00, 32'd0,  0, 1}; // prio held at 0
    vecs[19] = '{2'b00, 2'b11, 1, 4, 2, 2'b00, 2'b01, 32'd2,  1, 0};

    // Reset with requests pending at the inputs.
    resetb = 1'b0; clk_en = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
    apply_sets(0, 2);
    #3;
    chk("rst rr ready", {30'd0, rr_ready}, 32'd0);
    chk("rst rr rspv", {30'd0, rr_valid}, 32'd0);
    chk("rst rr alu_en", {31'd0, rr_alu_en}, 32'd0);
    chk("rst fp ready", {30'd0, fp_ready}, 32'd0);
    chk("rst fp rspv", {30'd0, fp_valid}, 32'd0);
    chk("rst fp alu_en", {31'd0, fp_alu_en}, 32'd0);
    @(posedge clk); #1;
    resetb = 1'b1;

    for (int i = 0; i < 20; i++) begin
      req_valid = vecs[i].valid; rsp_ready = vecs[i].rdy; clk_en = vecs[i].en;
      apply_sets(vecs[i].s0, vecs[i].s1);
      #4;
      chk($sformatf("v%0d ready", i), {30'd0, rr_ready}, {30'd0, vecs[i].ex_ready});
      chk($sformatf("v%0d rspv", i), {30'd0, rr_valid}, {30'd0, vecs[i].ex_valid});
      chk($sformatf("v%0d alu_en", i), {31'd0, rr_alu_en}, {31'd0, vecs[i].ex_alu_en});
      if (vecs[i].ex_valid != 2'b00) begin
        chk($sformatf("v%0d result", i), rr_rsp_res, vecs[i].ex_res);
        chk($sformatf("v%0d cmp", i), {31'd0, rr_rsp_cmp}, {31'd0, vecs[i].ex_cmp});
      end
      @(posedge clk); #1;
    end

    // Async reset while a result is pending: discarded, no response afterwards.
    req_valid = 2'b01; rsp_ready = 2'b00; clk_en = 1'b1;
    apply_sets(0, 2);
    #4;
    chk("ar issue", {30'd0, rr_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    chk("ar pending", {30'd0, rr_valid}, 32'd1);
    #1;
    resetb = 1'b0;
    #1;
    chk("ar rr rspv", {30'd0, rr_valid}, 32'd0);
    chk("ar fp rspv", {30'd0, fp_valid}, 32'd0);
    @(posedge clk); #1;
    resetb = 1'b1;

    // Contention after reset: RR grants 0,1,0,1; fixed priority always 0.
    req_valid = 2'b11; rsp_ready = 2'b11;
    apply_sets(1, 2);
    for (int i = 0; i < 4; i++) begin
      #4;
      chk($sformatf("c%0d rr ready", i), {30'd0, rr_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("c%0d fp ready", i), {30'd0, fp_ready}, 32'd1);
      if (i == 0) begin
        chk("c0 rr rspv", {30'd0, rr_valid}, 32'd0);
        chk("c0 fp rspv", {30'd0, fp_valid}, 32'd0);
      end else begin
        chk($sformatf("c%0d rr rspv", i), {30'd0, rr_valid}, (i % 2 == 1) ? 32'd1 : 32'd2);
        chk($sformatf("c%0d rr res", i), rr_rsp_res, (i % 2 == 1) ? 32'd7 : 32'd1);
        chk($sformatf("c%0d fp rspv", i), {30'd0, fp_valid}, 32'd1);
        chk($sformatf("c%0d fp res", i), fp_rsp_res, 32'd7);
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
